// File: rtl/sec_scrub_ctrl.sv
// rtl/sec_scrub_ctrl.sv - background SEC scrubber for 136-bit codeword SRAM
//
// Walks addresses 0..DEPTH-1, reads each codeword, lets the external SEC
// decoder/encoder pair rebuild it, and writes it back only when the rebuilt
// codeword differs from what was read.
//
// Optional build macro: SCRUB_ERR_LOG_EN (builds the last-corrected-address log).
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   scrub_en          level enable (finishes the current address when dropped)
//   clear_cnt         sync clear of err_cnt (and last_err_vld when logging)
//   mem_req/we/addr   memory request, held stable until mem_gnt
//   mem_wdata         write-back codeword
//   mem_gnt           arbiter grant
//   mem_rvalid/rdata  read response
//   dec_codeword      captured codeword to the SEC decoder
//   dec_message       corrected message from the SEC decoder
//   enc_message       message to the SEC encoder
//   enc_codeword      re-encoded codeword from the SEC encoder
//   busy              read granted, address not yet finished
//   pass_done         1-cycle pulse when address DEPTH-1 finishes
//   err_cnt           saturating corrected-word counter
//   last_err_addr/vld most recent corrected address (logging builds only)
module sec_scrub_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int INTERVAL = 256,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scrub_en,
  input  logic              clear_cnt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [135:0]      mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [135:0]      mem_rdata,
  output logic [135:0]      dec_codeword,
  input  logic [127:0]      dec_message,
  output logic [127:0]      enc_message,
  input  logic [135:0]      enc_codeword,
  output logic              busy,
  output logic              pass_done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] last_err_addr,
  output logic              last_err_vld
);

  localparam int TMR_W = (INTERVAL < 1) ? 1 : $clog2(INTERVAL + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(INTERVAL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_CHECK,
    S_WR,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [135:0]       cw_q;
  logic [135:0]       wdata_q;
  logic               busy_q;
  logic               pass_q;
  logic [CNT_W-1:0]   cnt_q;

  logic mismatch;
  logic corrected;
  logic gap_entry;

  // Any difference (data or check bits) means the stored word is not the
  // canonical encoding of the corrected message and must be rewritten.
  assign mismatch  = (enc_codeword != cw_q);
  assign corrected = (state_q == S_CHECK) && mismatch;
  // The address is finished either straight from CHECK or once the write is granted.
  assign gap_entry = ((state_q == S_CHECK) && !mismatch) ||
                     ((state_q == S_WR) && mem_gnt);

  assign mem_addr     = ptr_q;
  assign mem_wdata    = wdata_q;
  assign dec_codeword = cw_q;
  assign enc_message  = dec_message;
  assign busy         = busy_q;
  assign pass_done    = pass_q;
  assign err_cnt      = cnt_q;

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scrub_en) state_d = S_RD_REQ;
      end
      S_RD_REQ: begin
        mem_req = 1'b1;
        // A grant in the same cycle as the enable drop still commits the read.
        if (mem_gnt)        state_d = S_RD_WAIT;
        else if (!scrub_en) state_d = S_IDLE;
      end
      S_RD_WAIT: begin
        if (mem_rvalid) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = mismatch ? S_WR : S_GAP;
      end
      S_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt) state_d = S_GAP;
      end
      S_GAP: begin
        if (tmr_q == '0) state_d = scrub_en ? S_RD_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      tmr_q   <= '0;
      cw_q    <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= gap_entry && (ptr_q == LAST_ADDR);

      if (gap_entry) begin
        ptr_q <= (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(1);
      end

      if (gap_entry) begin
        tmr_q <= TMR_LOAD;
      end else if ((state_q == S_GAP) && (tmr_q != '0)) begin
        tmr_q <= tmr_q - TMR_W'(1);
      end

      if ((state_q == S_RD_REQ) && mem_gnt) begin
        busy_q <= 1'b1;
      end else if (gap_entry) begin
        busy_q <= 1'b0;
      end

      if ((state_q == S_RD_WAIT) && mem_rvalid) begin
        cw_q <= mem_rdata;
      end

      if (corrected) begin
        wdata_q <= enc_codeword;
      end

      if (clear_cnt) begin
        cnt_q <= '0;
      end else if (corrected && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef SCRUB_ERR_LOG_EN
  logic [ADDR_W-1:0] log_addr_q;
  logic              log_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_addr_q <= '0;
      log_vld_q  <= 1'b0;
    end else begin
      if (corrected) begin
        log_addr_q <= ptr_q;
      end
      // A correction in the same cycle as the clear still leaves a valid entry.
      if (corrected) begin
        log_vld_q <= 1'b1;
      end else if (clear_cnt) begin
        log_vld_q <= 1'b0;
      end
    end
  end

  assign last_err_addr = log_addr_q;
  assign last_err_vld  = log_vld_q;
`else
  assign last_err_addr = '0;
  assign last_err_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_sec_scrub_ctrl.sv
// tb/tb_sec_scrub_ctrl.sv - directed self-checking bench for sec_scrub_ctrl
module tb_sec_scrub_ctrl;

  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 8;
  localparam int INTERVAL = 2;
  localparam int CNT_W    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              scrub_en;
  logic              clear_cnt;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [135:0]      mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [135:0]      mem_rdata;
  logic [135:0]      dec_codeword;
  logic [127:0]      dec_message;
  logic [127:0]      enc_message;
  logic [135:0]      enc_codeword;
  logic              busy;
  logic              pass_done;
  logic [CNT_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] last_err_addr;
  logic              last_err_vld;

  always #5 clk = ~clk;

  sec_scrub_ctrl #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INTERVAL(INTERVAL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .clear_cnt(clear_cnt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dec_codeword(dec_codeword), .dec_message(dec_message),
    .enc_message(enc_message), .enc_codeword(enc_codeword),
    .busy(busy), .pass_done(pass_done), .err_cnt(err_cnt),
    .last_err_addr(last_err_addr), .last_err_vld(last_err_vld)
  );

  // Hamming SEC over 128 data bits: data column i is the i-th 8-bit value
  // with two or more ones; check bit j has column 1<<j.
  function automatic logic [135:0] sec_enc(input logic [127:0] d);
    logic [7:0] c;
    int v;
    c = '0;
    v = 3;
    for (int i = 0; i < 128; i++) begin
      while ($countones(v) < 2) v++;
      if (d[i]) c ^= v[7:0];
      v++;
    end
    return {c, d};
  endfunction

  function automatic logic [127:0] sec_dec(input logic [135:0] cw);
    logic [135:0] re;
    logic [7:0]   s;
    logic [127:0] d;
    int v;
    d  = cw[127:0];
    re = sec_enc(d);
    s  = re[135:128] ^ cw[135:128];
    v  = 3;
    for (int i = 0; i < 128; i++) begin
      while ($countones(v) < 2) v++;
      if (s == v[7:0]) d[i] = ~d[i];
      v++;
    end
    return d;
  endfunction

  assign dec_message  = sec_dec(dec_codeword);
  assign enc_codeword = sec_enc(enc_message);

  // Memory model: read latency 2, grant driven from the stimulus block.
  logic [135:0]      mem [16];
  logic [135:0]      orig [16];
  logic              gnt_en;
  logic              poke_en = 1'b0;
  logic [3:0]        poke_addr = '0;
  logic [135:0]      poke_data = '0;
  logic [1:0]        rd_cnt = '0;
  logic [135:0]      rd_data = '0;
  int                rd_count = 0;
  int                wr_count = 0;
  int                pass_cnt = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [135:0]      last_wr_data = '0;

  assign mem_gnt    = gnt_en;
  assign mem_rvalid = (rd_cnt == 2'd1);
  assign mem_rdata  = rd_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else begin
      if (rd_cnt != '0) rd_cnt <= rd_cnt - 2'd1;
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          mem[mem_addr] <= mem_wdata;
          wr_count      <= wr_count + 1;
          last_wr_addr  <= mem_addr;
          last_wr_data  <= mem_wdata;
        end else begin
          rd_data      <= mem[mem_addr];
          rd_cnt       <= 2'd2;
          rd_count     <= rd_count + 1;
          last_rd_addr <= mem_addr;
        end
      end
      if (pass_done) pass_cnt <= pass_cnt + 1;
    end
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [135:0] d);
    poke_addr = 4'(a);
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  task automatic wait_pass(input string tag);
    int n;
    n = 0;
    while (!pass_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, pass_done, 1'b1);
  endtask

  int                n;
  int                rd_base;
  int                wr_base;
  logic              stable;
  logic              s_req, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [135:0]      s_wdata;

  initial begin
    rst_n     = 1'b0;
    scrub_en  = 1'b0;
    clear_cnt = 1'b0;
    gnt_en    = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      orig[a] = sec_enc({$urandom, $urandom, $urandom, $urandom});
      poke(a, orig[a]);
    end

    // Reset state
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pass_done", pass_done, 1'b0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_last_err_vld", last_err_vld, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: clean pass
    rd_base = rd_count; wr_base = wr_count;
    scrub_en = 1'b1;
    wait_pass("t1_pass_seen");
    chk("t1_last_rd_addr", last_rd_addr, DEPTH - 1);
    scrub_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_reads", rd_count - rd_base, DEPTH);
    chk("t1_writes", wr_count - wr_base, 0);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_ptr_wrapped", mem_addr, 0);
    chk("t1_pass_pulses", pass_cnt, 1);
    chk("t1_idle_req", mem_req, 1'b0);

    // 2: data bit 70 flipped at address 2
    poke(2, orig[2] ^ (136'(1) << 70));
    rd_base = rd_count; wr_base = wr_count;
    scrub_en = 1'b1;
    wait_pass("t2_pass_seen");
    scrub_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_writes", wr_count - wr_base, 1);
    chk("t2_wr_addr", last_wr_addr, 2);
    chk("t2_wr_data", last_wr_data, orig[2]);
    chk("t2_err_cnt", err_cnt, 1);
`ifdef SCRUB_ERR_LOG_EN
    chk("t2_last_err_addr", last_err_addr, 2);
    chk("t2_last_err_vld", last_err_vld, 1'b1);
`else
    chk("t2_last_err_addr", last_err_addr, 0);
    chk("t2_last_err_vld", last_err_vld, 1'b0);
`endif

    // 3: check bit 3 flipped at address 1
    clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
    chk("t3_cleared", err_cnt, 0);
    chk("t3_log_cleared", last_err_vld, 1'b0);
    poke(1, orig[1] ^ (136'(1) << 131));
    wr_base = wr_count;
    scrub_en = 1'b1;
    wait_pass("t3_pass_seen");
    scrub_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("t3_writes", wr_count - wr_base, 1);
    chk("t3_wr_addr", last_wr_addr, 1);
    chk("t3_wr_data", last_wr_data, orig[1]);
    chk("t3_err_cnt", err_cnt, 1);
`ifdef SCRUB_ERR_LOG_EN
    chk("t3_last_err_addr", last_err_addr, 1);
`endif

    // 4: grant withheld 5 cycles in RD_REQ and in WR
    poke(0, orig[0] ^ (136'(1) << 5));
    rd_base = rd_count; wr_base = wr_count;
    gnt_en = 1'b0;
    scrub_en = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    chk("t4_rd_req_seen", mem_req, 1'b1);
    chk("t4_rd_addr", mem_addr, 0);
    s_req = mem_req; s_we = mem_we; s_addr = mem_addr;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_req !== s_req || mem_we !== s_we || mem_addr !== s_addr) stable = 1'b0;
    end
    chk("t4_rd_stable", stable, 1'b1);
    gnt_en = 1'b1;
    @(negedge clk);
    gnt_en = 1'b0;
    n = 0;
    while (!(mem_req && mem_we) && n < 20) begin @(negedge clk); n++; end
    chk("t4_wr_req_seen", mem_req && mem_we, 1'b1);
    s_addr = mem_addr; s_wdata = mem_wdata;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!mem_req || !mem_we || mem_addr !== s_addr || mem_wdata !== s_wdata) stable = 1'b0;
    end
    chk("t4_wr_stable", stable, 1'b1);
    chk("t4_wr_addr", mem_addr, 0);
    chk("t4_wr_data", mem_wdata, orig[0]);
    chk("t4_wr_before_gnt", wr_count - wr_base, 0);
    gnt_en = 1'b1;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    scrub_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_reads", rd_count - rd_base, 1);
    chk("t4_writes", wr_count - wr_base, 1);

    // 5: enable dropped during the read of address 5
    rd_base = rd_count;
    scrub_en = 1'b1;
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 5) && n < 200) begin @(negedge clk); n++; end
    chk("t5_addr5_req", mem_addr, 5);
    @(negedge clk);
    chk("t5_busy_rd_wait", busy, 1'b1);
    scrub_en = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_idle_req", mem_req, 1'b0);
    chk("t5_last_rd", last_rd_addr, 5);
    chk("t5_ptr_next", mem_addr, 6);
    chk("t5_reads", rd_count - rd_base, 5);
    gnt_en = 1'b0;
    scrub_en = 1'b1;
    n = 0;
    while (!mem_req && n < 10) begin @(negedge clk); n++; end
    chk("t5_resume_addr", mem_addr, 6);
    scrub_en = 1'b0;
    @(negedge clk);
    chk("t5_drop_before_gnt", mem_req, 1'b0);
    chk("t5_no_extra_read", rd_count - rd_base, 5);
    gnt_en = 1'b1;

    // 6: saturation at 3, clear coincident with 5th increment, reset mid-WR
    clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
    chk("t6_cleared", err_cnt, 0);
    poke(6, orig[6] ^ (136'(1) << 0));
    poke(7, orig[7] ^ (136'(1) << 100));
    poke(0, orig[0] ^ (136'(1) << 127));
    poke(1, orig[1] ^ (136'(1) << 133));
    poke(2, orig[2] ^ (136'(1) << 64));
    wr_base = wr_count;
    scrub_en = 1'b1;
    n = 0;
    while (!(mem_rvalid && last_rd_addr == 2) && n < 300) begin @(negedge clk); n++; end
    chk("t6_rvalid_addr2", mem_rvalid, 1'b1);
    chk("t6_saturated", err_cnt, 3);
    chk("t6_writes4", wr_count - wr_base, 4);
    @(negedge clk);
    clear_cnt = 1'b1;
    gnt_en = 1'b0;
    @(negedge clk);
    clear_cnt = 1'b0;
    chk("t6_clear_wins", err_cnt, 0);
    chk("t6_in_wr", mem_req && mem_we, 1'b1);
    chk("t6_wr_addr", mem_addr, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", mem_req, 1'b0);
    chk("t6_rst_we", mem_we, 1'b0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_wdata", mem_wdata, 0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_dec_cw", dec_codeword, 0);
    scrub_en = 1'b0;
    gnt_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_partial_write", wr_count - wr_base, 4);
    chk("t6_post_rst_req", mem_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
